// File: rtl/checker_arb.sv
// rtl/checker_arb.sv - two-requester round-robin arbiter in front of a shared checker
// Optional grant counters gnt_cnt0/gnt_cnt1 are built only when CHK_ARB_GRANT_CNT_EN is defined.
module checker_arb #(
    parameter int RSP_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [9:0]  req0_x,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [9:0]  req1_x,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [10:0] rsp_y,
    input  logic        rsp_ready,
    output logic [9:0]  chk_x,
    output logic        chk_key,
    output logic        chk_rst,
    input  logic [10:0] chk_y,
    input  logic        cfg_key_we,
    input  logic        cfg_key,
    input  logic        cfg_flush,
`ifdef CHK_ARB_GRANT_CNT_EN
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1,
`endif
    output logic        busy
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(RSP_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  wait_cnt;
    logic [9:0]  x_lat;
    logic        owner;
    logic        rr_ptr;
    logic        shadow_key;
    logic        flush_pend;
    logic        flush_req;
    logic        gnt_any;
    logic        gnt_id;

    // Grant decision: a pending flush blocks grants; rr_ptr only breaks ties.
    always_comb begin
        flush_req = flush_pend | cfg_flush;
        gnt_id    = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
        gnt_any   = 1'b0;
        if (!rst && state == S_IDLE && !flush_req && (req0_valid || req1_valid)) begin
            gnt_any = 1'b1;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        chk_x      = 10'd0;
        chk_rst    = 1'b0;
        busy       = 1'b1;
        case (state)
            S_INIT: begin
                chk_rst   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                busy = 1'b0;
                if (flush_req) begin
                    state_nxt = S_INIT;
                end else if (gnt_any) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                chk_x = x_lat;
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                chk_x     = x_lat;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
        if (rst) begin
            state_nxt  = S_INIT;
            req0_ready = 1'b0;
            req1_ready = 1'b0;
            rsp_valid  = 1'b0;
            chk_x      = 10'd0;
            chk_rst    = 1'b1;
            busy       = 1'b1;
        end
    end

    // State register; reset forces INIT through state_nxt.
    always_ff @(posedge clk) begin
        state <= state_nxt;
    end

    // Datapath: latched request, wait counter, key shadowing, flush latch, response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 3'd0;
            x_lat      <= 10'd0;
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            shadow_key <= 1'b0;
            flush_pend <= 1'b0;
            chk_key    <= 1'b0;
            rsp_y      <= 11'd0;
            rsp_id     <= 1'b0;
        end else begin
            if (cfg_key_we) begin
                shadow_key <= cfg_key;
            end
            if (state == S_IDLE && flush_req) begin
                flush_pend <= 1'b0;
            end else if (cfg_flush) begin
                flush_pend <= 1'b1;
            end
            // Key moves only between transactions, so a checker run never sees it change.
            if (state == S_IDLE && !gnt_any) begin
                chk_key <= shadow_key;
            end
            if (gnt_any) begin
                x_lat    <= gnt_id ? req1_x : req0_x;
                owner    <= gnt_id;
                rr_ptr   <= ~gnt_id;
                wait_cnt <= 3'd0;
            end
            if (state == S_ISSUE) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            if (state == S_CAPTURE) begin
                rsp_y  <= chk_y;
                rsp_id <= owner;
            end
        end
    end

`ifdef CHK_ARB_GRANT_CNT_EN
    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= 16'd0;
            gnt_cnt1 <= 16'd0;
        end else if (gnt_any) begin
            if (!gnt_id && gnt_cnt0 != 16'hFFFF) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (gnt_id && gnt_cnt1 != 16'hFFFF) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_checker_arb.sv
// tb/tb_checker_arb.sv - self-checking bench for checker_arb with a transaction-level model
module tb_checker_arb;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [9:0]  req0_x, req1_x;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id;
    logic [10:0] rsp_y;
    logic        rsp_ready;
    logic [9:0]  chk_x;
    logic        chk_key, chk_rst;
    logic [10:0] chk_y;
    logic        cfg_key_we, cfg_key, cfg_flush;
    logic        busy;
`ifdef CHK_ARB_GRANT_CNT_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    int passed = 0;
    int total  = 0;

    // model state: preferred requester, active key, grant counts
    int mrr   = 0;
    int mkey  = 0;
    int mcnt0 = 0;
    int mcnt1 = 0;

    checker_arb #(.RSP_WAIT(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
        .chk_x(chk_x), .chk_key(chk_key), .chk_rst(chk_rst), .chk_y(chk_y),
        .cfg_key_we(cfg_key_we), .cfg_key(cfg_key), .cfg_flush(cfg_flush),
`ifdef CHK_ARB_GRANT_CNT_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // checker model: f(x) = 3x + 0x44B mod 2^11, so f(0x3FF) = 0x048
    function automatic logic [10:0] chk_f(input logic [9:0] x);
        logic [10:0] t;
        t = {1'b0, x} * 11'd3 + 11'h44B;
        return t;
    endfunction

    assign chk_y = chk_f(chk_x);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full transaction from the IDLE cycle where requests are presented.
    task automatic do_txn(input logic v0, input logic v1, input logic [9:0] x0,
                          input logic [9:0] x1, input int dly, input bit keep,
                          input bit cfg, input bit abort);
        int          g;
        logic [9:0]  gx;
        logic [10:0] ey;
        req0_valid = v0;
        req1_valid = v1;
        req0_x     = x0;
        req1_x     = x1;
        #1;
        g  = (v0 && v1) ? mrr : (v0 ? 0 : 1);
        gx = (g == 1) ? x1 : x0;
        ey = chk_f(gx);
        check("idle_busy", busy, 0);
        check("grant_ready0", req0_ready, g == 0);
        check("grant_ready1", req1_ready, g == 1);
        mrr = 1 - g;
        if (g == 0) mcnt0++; else mcnt1++;
        tick();
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
            if (cfg && i == 0) begin
                cfg_key_we = 1'b1;
                cfg_key    = 1'b1;
                cfg_flush  = 1'b1;
            end
            #1;
            check("issue_chk_x", chk_x, gx);
            check("issue_no_ready", {req0_ready, req1_ready}, 0);
            check("issue_rsp_valid", rsp_valid, 0);
            check("issue_key", chk_key, mkey);
            check("issue_busy", busy, 1);
            tick();
            cfg_key_we = 1'b0;
            cfg_flush  = 1'b0;
        end
        #1;
        check("capture_chk_x", chk_x, gx);
        check("capture_rsp_valid", rsp_valid, 0);
        if (abort) begin
            rst = 1'b1;
            tick();
            check("abort_rsp_valid", rsp_valid, 0);
            check("abort_chk_rst", chk_rst, 1);
            check("abort_chk_x", chk_x, 0);
            rst   = 1'b0;
            mrr   = 0;
            mkey  = 0;
            mcnt0 = 0;
            mcnt1 = 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("post_abort_rsp_valid", rsp_valid, 0);
                check("post_abort_busy", busy, 0);
                check("post_abort_rsp_y", rsp_y, 0);
            end
            return;
        end
        tick();
        #1;
        check("resp_valid", rsp_valid, 1);
        check("resp_y", rsp_y, ey);
        check("resp_id", rsp_id, g);
        check("resp_chk_x", chk_x, 0);
        for (int d = 0; d < dly; d++) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_y", rsp_y, ey);
            check("hold_id", rsp_id, g);
            check("hold_no_grant", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("back_idle_busy", busy, 0);
        check("back_idle_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_x     = 10'd0;
        req1_x     = 10'd0;
        rsp_ready  = 1'b0;
        cfg_key_we = 1'b0;
        cfg_key    = 1'b0;
        cfg_flush  = 1'b0;
        tick();
        tick();
        req0_valid = 1'b1;
        #1;
        check("rst_chk_rst", chk_rst, 1);
        check("rst_busy", busy, 1);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_chk_x", chk_x, 0);
        check("rst_chk_key", chk_key, 0);
        req0_valid = 1'b0;
        rst        = 1'b0;
        #1;
        check("first_cycle_chk_rst", chk_rst, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_chk_rst", chk_rst, 0);
            check("idle_busy0", busy, 0);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_chk_x", chk_x, 0);
        end

        // continuous contention from reset: expect 0,1,0,1
        for (int t = 0; t < 4; t++) begin
            do_txn(1'b1, 1'b1, 10'(t * 37 + 5), 10'(t * 91 + 2), 0, 1'b1, 1'b0, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // lone requesters; requester 1 alone right after pointer prefers 0
        do_txn(1'b1, 1'b0, 10'h3FF, 10'h000, 0, 1'b0, 1'b0, 1'b0);
        check("direct_y_3ff", rsp_y, 11'h048);
        do_txn(1'b1, 1'b1, 10'h155, 10'h2AA, 0, 1'b0, 1'b0, 1'b0);
        do_txn(1'b0, 1'b1, 10'h001, 10'h0F0, 0, 1'b0, 1'b0, 1'b0);

        // long hold in RESP with both requesters waiting
        do_txn(1'b1, 1'b1, 10'h123, 10'h321, 5, 1'b1, 1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // key write and flush during ISSUE
        do_txn(1'b1, 1'b0, 10'h0AA, 10'h000, 1, 1'b0, 1'b1, 1'b0);
        req1_valid = 1'b1;
        #1;
        check("flush_prio_no_grant", {req0_ready, req1_ready}, 0);
        check("flush_idle_key_old", chk_key, 0);
        tick();
        mkey = 1;
        check("flush_init_chk_rst", chk_rst, 1);
        check("flush_init_busy", busy, 1);
        check("flush_init_key", chk_key, 1);
        tick();
        check("after_init_chk_rst", chk_rst, 0);
        check("after_init_key", chk_key, 1);
        do_txn(1'b0, 1'b1, 10'h000, 10'h1C3, 0, 1'b0, 1'b0, 1'b0);

        // randomized transactions
        for (int r = 0; r < 16; r++) begin
            int v;
            v = $urandom_range(1, 3);
            do_txn(v[0], v[1], 10'($urandom), 10'($urandom), $urandom_range(0, 3),
                   1'b0, 1'b0, 1'b0);
        end

`ifdef CHK_ARB_GRANT_CNT_EN
        check("gnt_cnt0_model", gnt_cnt0, mcnt0);
        check("gnt_cnt1_model", gnt_cnt1, mcnt1);
`endif

        // reset during CAPTURE
        do_txn(1'b1, 1'b0, 10'h2F0, 10'h000, 0, 1'b0, 1'b0, 1'b1);
`ifdef CHK_ARB_GRANT_CNT_EN
        check("gnt_cnt0_cleared", gnt_cnt0, 0);
        check("gnt_cnt1_cleared", gnt_cnt1, 0);
`endif
        // pointer was cleared by reset: contention goes to requester 0
        do_txn(1'b1, 1'b1, 10'h00F, 10'h0F0, 0, 1'b0, 1'b0, 1'b0);
        check("post_rst_key", chk_key, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
